// File: rtl/collision_pkg.sv
// ============================================================================
// Module      : collision_pkg
// Description : Shared FSM encoding, position helper type and index-width
//               function for the collision scan unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package collision_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int POS_W_DEFAULT = 8;
    typedef logic [POS_W_DEFAULT-1:0] pos_t;

    // A single-segment build still needs a 1-bit index to keep ports legal.
    function automatic int seg_idx_w(input int num_seg);
        return (num_seg > 1) ? $clog2(num_seg) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/collision_scan_unit_if.sv
// ============================================================================
// Module      : collision_scan_unit_if
// Description : Request/result bundle between position logic (master) and the
//               collision scan unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface collision_scan_unit_if #(
    parameter int POS_W     = 8,
    parameter int NUM_SEG   = 7,
    parameter int NUM_PROBE = 2
);
    localparam int SEG_IDX_W = collision_pkg::seg_idx_w(NUM_SEG);

    logic                           start;
    logic [NUM_PROBE*POS_W-1:0]     probe_pos;
    logic [NUM_PROBE-1:0]           probe_vld;
    logic [NUM_SEG*POS_W-1:0]       seg_pos;
    logic [NUM_SEG-1:0]             seg_active;
    logic                           busy;
    logic                           done;
    logic [NUM_PROBE-1:0]           hit;
    logic                           any_hit;
    logic [NUM_PROBE*SEG_IDX_W-1:0] hit_idx;

    modport master (
        output start, probe_pos, probe_vld, seg_pos, seg_active,
        input  busy, done, hit, any_hit, hit_idx
    );

    modport slave (
        input  start, probe_pos, probe_vld, seg_pos, seg_active,
        output busy, done, hit, any_hit, hit_idx
    );

endinterface

`default_nettype wire

// File: rtl/collision_scan_unit_pos_match_array.sv
// ============================================================================
// Module      : pos_match_array
// Description : One segment position compared against every probe in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pos_match_array #(
    parameter int POS_W     = 8,
    parameter int NUM_PROBE = 2
) (
    input  wire logic [NUM_PROBE*POS_W-1:0] i_probe_pos,
    input  wire logic [NUM_PROBE-1:0]       i_probe_vld,
    input  wire logic [POS_W-1:0]           i_seg_pos,
    input  wire logic                       i_seg_active,
    output logic      [NUM_PROBE-1:0]       o_match
);

    for (genvar p = 0; p < NUM_PROBE; p++) begin : g_probe
        assign o_match[p] = i_probe_vld[p] & i_seg_active &
                            (i_probe_pos[p*POS_W +: POS_W] == i_seg_pos);
    end

endmodule

`default_nettype wire

// File: rtl/collision_scan_unit.sv
// ============================================================================
// Module      : collision_scan_unit
// Description : Time-multiplexed probe-vs-segment collision checker, one
//               segment per clock. Define COLLISION_FIRST_HIT_IDX_EN to build
//               the lowest-hitting-segment index registers behind hit_idx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_scan_unit
    import collision_pkg::*;
#(
    parameter int POS_W     = 8,
    parameter int NUM_SEG   = 7,
    parameter int NUM_PROBE = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    collision_scan_unit_if.slave   bus
);

    localparam int SEG_IDX_W = seg_idx_w(NUM_SEG);
    localparam logic [SEG_IDX_W-1:0] c_last_idx = SEG_IDX_W'(NUM_SEG - 1);

    logic [1:0]                 r_state;
    logic [SEG_IDX_W-1:0]       r_idx;
    logic [NUM_PROBE*POS_W-1:0] r_probe_pos;
    logic [NUM_PROBE-1:0]       r_probe_vld;
    logic [NUM_SEG*POS_W-1:0]   r_seg_pos;
    logic [NUM_SEG-1:0]         r_seg_active;
    logic [NUM_PROBE-1:0]       r_acc;
    logic                       r_done;
    logic [NUM_PROBE-1:0]       r_hit;
    logic                       r_any_hit;

    logic                       w_load;
    logic [POS_W-1:0]           w_seg_pos;
    logic                       w_seg_active;
    logic [NUM_PROBE-1:0]       w_match;

    // DONE accepts a new request just like IDLE so scans can run back to back.
    assign w_load       = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_seg_pos    = r_seg_pos[r_idx*POS_W +: POS_W];
    assign w_seg_active = r_seg_active[r_idx];

    pos_match_array #(
        .POS_W     (POS_W),
        .NUM_PROBE (NUM_PROBE)
    ) u_match (
        .i_probe_pos  (r_probe_pos),
        .i_probe_vld  (r_probe_vld),
        .i_seg_pos    (w_seg_pos),
        .i_seg_active (w_seg_active),
        .o_match      (w_match)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_probe_pos  <= '0;
            r_probe_vld  <= '0;
            r_seg_pos    <= '0;
            r_seg_active <= '0;
            r_acc        <= '0;
            r_done       <= 1'b0;
            r_hit        <= '0;
            r_any_hit    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SCAN: begin
                    r_acc <= r_acc | w_match;
                    if (r_idx == c_last_idx) r_state <= DONE;
                    else                     r_idx   <= r_idx + SEG_IDX_W'(1);
                end
                DONE: begin
                    r_done    <= 1'b1;
                    r_hit     <= r_acc;
                    r_any_hit <= |r_acc;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_load) begin
                r_probe_pos  <= bus.probe_pos;
                r_probe_vld  <= bus.probe_vld;
                r_seg_pos    <= bus.seg_pos;
                r_seg_active <= bus.seg_active;
                r_acc        <= '0;
                r_idx        <= '0;
                r_state      <= SCAN;
            end
        end
    end

`ifdef COLLISION_FIRST_HIT_IDX_EN
    logic [SEG_IDX_W-1:0]           r_first_idx [NUM_PROBE];
    logic [NUM_PROBE*SEG_IDX_W-1:0] r_hit_idx;

    // Capture only on the rising edge of acc so the lowest index wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PROBE; p++) r_first_idx[p] <= '0;
            r_hit_idx <= '0;
        end else begin
            if (r_state == DONE) begin
                for (int p = 0; p < NUM_PROBE; p++)
                    r_hit_idx[p*SEG_IDX_W +: SEG_IDX_W] <= r_acc[p] ? r_first_idx[p] : '0;
            end
            if (w_load) begin
                for (int p = 0; p < NUM_PROBE; p++) r_first_idx[p] <= '0;
            end else if (r_state == SCAN) begin
                for (int p = 0; p < NUM_PROBE; p++)
                    if (w_match[p] && !r_acc[p]) r_first_idx[p] <= r_idx;
            end
        end
    end

    assign bus.hit_idx = r_hit_idx;
`else
    assign bus.hit_idx = '0;
`endif

    assign bus.busy    = (r_state == SCAN);
    assign bus.done    = r_done;
    assign bus.hit     = r_hit;
    assign bus.any_hit = r_any_hit;

endmodule

`default_nettype wire

// File: tb/tb_collision_scan_unit.sv
// ============================================================================
// Module      : tb_collision_scan_unit
// Description : Table-driven bench for collision_scan_unit (7 segments,
//               2 probes) plus hand-written snapshot, reset and streaming runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_scan_unit;

    localparam int POS_W     = 8;
    localparam int NUM_SEG   = 7;
    localparam int NUM_PROBE = 2;

    typedef struct {
        logic [15:0] probe_pos;
        logic [1:0]  probe_vld;
        logic [55:0] seg_pos;
        logic [6:0]  seg_active;
        logic [1:0]  exp_hit;
        logic [2:0]  exp_idx0;
        logic [2:0]  exp_idx1;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    collision_scan_unit_if #(.POS_W(POS_W), .NUM_SEG(NUM_SEG), .NUM_PROBE(NUM_PROBE)) bus ();

    collision_scan_unit #(.POS_W(POS_W), .NUM_SEG(NUM_SEG), .NUM_PROBE(NUM_PROBE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] exp_hit_idx(input vec_t v);
`ifdef COLLISION_FIRST_HIT_IDX_EN
        return {v.exp_idx1, v.exp_idx0};
`else
        return 6'd0;
`endif
    endfunction

    task automatic apply(input vec_t v);
        bus.probe_pos  = v.probe_pos;
        bus.probe_vld  = v.probe_vld;
        bus.seg_pos    = v.seg_pos;
        bus.seg_active = v.seg_active;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, " hit"},     64'(bus.hit),     64'(v.exp_hit));
        check({tag, " any_hit"}, 64'(bus.any_hit), 64'(|v.exp_hit));
        check({tag, " hit_idx"}, 64'(bus.hit_idx), 64'(exp_hit_idx(v)));
    endtask

    // Start pulse, then measure start-to-done latency and check results.
    task automatic run_scan(input string tag, input vec_t v);
        int cyc;
        apply(v);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(NUM_SEG + 1));
        check_result(tag, v);
        tick();
        check({tag, " done pulse"}, 64'(bus.done), 64'd0);
    endtask

    vec_t vecs [8];

    initial begin
        int   done_cnt;
        int   first_done;
        int   last_done;
        int   bad_gap;
        vec_t v;

        n_pass  = 0;
        n_total = 0;

        // probe_pos = {probe1, probe0}; seg_pos = {seg6 .. seg0}
        vecs[0] = '{16'h9934, 2'b11, 56'h56_55_54_53_34_51_50, 7'h7F, 2'b01, 3'd2, 3'd0};
        vecs[1] = '{16'h9934, 2'b11, 56'h56_55_54_53_34_51_50, 7'b1111011, 2'b00, 3'd0, 3'd0};
        vecs[2] = '{16'h9934, 2'b10, 56'h56_55_54_53_34_51_50, 7'h7F, 2'b00, 3'd0, 3'd0};
        vecs[3] = '{16'h1111, 2'b11, 56'h60_11_62_63_64_11_66, 7'h7F, 2'b11, 3'd1, 3'd1};
        vecs[4] = '{16'h6620, 2'b11, 56'h66_71_72_73_74_75_20, 7'h7F, 2'b11, 3'd0, 3'd6};
        vecs[5] = '{16'h4242, 2'b01, 56'h80_81_42_42_84_85_86, 7'h7F, 2'b01, 3'd3, 3'd0};
        vecs[6] = '{16'h4334, 2'b11, 56'h35_24_33_44_53_42_30, 7'h7F, 2'b00, 3'd0, 3'd0};
        vecs[7] = '{16'h3434, 2'b11, 56'h34_34_34_34_34_34_34, 7'h00, 2'b00, 3'd0, 3'd0};

        bus.start = 1'b0;
        apply(vecs[0]);
        reset = 1'b0;
        tick();
        tick();
        check("reset busy",    64'(bus.busy),    64'd0);
        check("reset done",    64'(bus.done),    64'd0);
        check("reset hit",     64'(bus.hit),     64'd0);
        check("reset any_hit", 64'(bus.any_hit), 64'd0);
        check("reset hit_idx", 64'(bus.hit_idx), 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_scan($sformatf("vec%0d", i), vecs[i]);
            tick();
            check($sformatf("vec%0d hold", i), 64'(bus.hit), 64'(vecs[i].exp_hit));
        end

        // Scramble inputs and pulse start during SCAN: snapshot must win, one done.
        v = vecs[4];
        apply(v);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_cnt   = 0;
        first_done = 0;
        for (int c = 1; c <= 14; c++) begin
            bus.probe_pos = 16'(c * 16'h0101);
            bus.seg_pos   = {7{8'(c)}};
            bus.probe_vld = 2'b11;
            bus.start     = (c == 2 || c == 4);
            if (c == 3) check("snap hold during scan", 64'(bus.hit), 64'(vecs[7].exp_hit));
            tick();
            if (bus.done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
                check_result("snap", v);
            end
        end
        bus.start = 1'b0;
        check("snap done count", 64'(done_cnt),   64'd1);
        check("snap latency",    64'(first_done), 64'(NUM_SEG + 1));

        // Reset during SCAN aborts without done and clears outputs.
        apply(vecs[3]);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort busy",    64'(bus.busy),    64'd0);
        check("abort done",    64'(bus.done),    64'd0);
        check("abort hit",     64'(bus.hit),     64'd0);
        check("abort any_hit", 64'(bus.any_hit), 64'd0);
        check("abort hit_idx", 64'(bus.hit_idx), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("abort no done", 64'(done_cnt), 64'd0);
        run_scan("after abort", vecs[3]);

        // start held high: a done every NUM_SEG+1 cycles.
        apply(vecs[0]);
        bus.start = 1'b1;
        tick();
        done_cnt  = 0;
        last_done = 0;
        bad_gap   = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus.done) begin
                if (c - last_done != NUM_SEG + 1) bad_gap++;
                last_done = c;
                done_cnt++;
            end
        end
        bus.start = 1'b0;
        check("stream done count", 64'(done_cnt), 64'd3);
        check("stream spacing",    64'(bad_gap),  64'd0);
        check_result("stream", vecs[0]);
        for (int c = 0; c < 10; c++) tick();
        check("stream idle busy", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
